// File: rtl/skew_search_ctl.sv
// Successive-approximation skew search over N_CH channels, each trial code qualified by a
// majority vote of SAMPLES comparator strobes. Optional REQ watchdog: SKEW_SEARCH_TIMEOUT_EN.
module skew_search_ctl #(
    parameter int CODE_W  = 10,
    parameter int N_CH    = 4,
    parameter int SAMPLES = 5,
    parameter int SETTLE  = 4,
    parameter int TMO     = 1023,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     run_i,
    input  logic                     cmp_out_i,
    output logic [CODE_W-1:0]        delay_code_o,
    output logic [CH_W-1:0]          ch_sel_o,
    output logic                     stb_req_o,
    input  logic                     stb_valid_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [N_CH*CODE_W-1:0]   result_o
);
    localparam int B_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int S_W = $clog2(SAMPLES + 1);

    if (SAMPLES % 2 == 0 || SAMPLES > 255 || SETTLE > 255 || N_CH < 1 || TMO < 1) begin : g_param_chk
        $error("skew_search_ctl: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_SET, S_SETTLE, S_REQ, S_DECIDE, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t                         state_q, state_d;
    logic                           run_prev_q;
    logic [CODE_W-1:0]              work_q, work_d;
    logic [B_W-1:0]                 bit_q, bit_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [7:0]                     settle_q, settle_d;
    logic [S_W-1:0]                 ones_q, ones_d;
    logic [S_W-1:0]                 samp_q, samp_d;
    logic [CODE_W-1:0]              code_q, code_d;
    logic                           busy_q, busy_d;
    logic                           stb_q, stb_d;
    logic                           done_q, done_d;
    logic [N_CH-1:0][CODE_W-1:0]    result_q, result_d;
    logic                           keep;
    logic [CODE_W-1:0]              trial;
`ifdef SKEW_SEARCH_TIMEOUT_EN
    localparam int T_W = $clog2(TMO + 1);
    logic [T_W-1:0]                 tmo_q, tmo_d;
    logic                           err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        ones_d   = ones_q;
        samp_d   = samp_q;
        code_d   = code_q;
        done_d   = done_q;
        result_d = result_q;
`ifdef SKEW_SEARCH_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        keep  = ones_q > S_W'(SAMPLES / 2);
        trial = work_q | (keep ? (CODE_W'(1) << bit_q) : '0);

        case (state_q)
            S_IDLE: begin
                code_d = '0;
                ch_d   = '0;
                if (run_i && !run_prev_q) begin
                    state_d = S_INIT;
                    done_d  = 1'b0;
                end
            end
            // The trial code is loaded on the way into SET so the line settles for 1+SETTLE cycles.
            S_INIT: begin
                work_d  = '0;
                bit_d   = B_W'(CODE_W - 1);
                code_d  = CODE_W'(1) << (CODE_W - 1);
                state_d = S_SET;
            end
            S_SET: begin
                settle_d = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 8'd0) begin
                    ones_d  = '0;
                    samp_d  = '0;
`ifdef SKEW_SEARCH_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = S_REQ;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_REQ: begin
                if (stb_valid_i) begin
                    samp_d = samp_q + S_W'(1);
                    ones_d = ones_q + S_W'(cmp_out_i);
                    if (samp_q == S_W'(SAMPLES - 1))
                        state_d = S_DECIDE;
`ifdef SKEW_SEARCH_TIMEOUT_EN
                    tmo_d = '0;
                end else if (tmo_q == T_W'(TMO)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + T_W'(1);
`endif
                end
            end
            S_DECIDE: begin
                work_d = trial;
                if (bit_q == '0) begin
                    result_d[ch_q] = trial;
                    code_d         = trial;
                    state_d        = S_NEXT;
                end else begin
                    bit_d   = bit_q - B_W'(1);
                    code_d  = trial | (CODE_W'(1) << (bit_q - B_W'(1)));
                    state_d = S_SET;
                end
            end
            S_NEXT: begin
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_INIT;
                end
            end
            S_DONE:  ;
            S_ERR:   ;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything; a half-searched channel never reaches result_q.
        if (!run_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            done_d   = done_q;
            code_d   = '0;
            ch_d     = '0;
        end

        busy_d = (state_d == S_INIT) || (state_d == S_SET) || (state_d == S_SETTLE) ||
                 (state_d == S_REQ) || (state_d == S_DECIDE) || (state_d == S_NEXT);
        stb_d  = (state_d == S_REQ);
`ifdef SKEW_SEARCH_TIMEOUT_EN
        err_d  = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            run_prev_q <= 1'b0;
            work_q     <= '0;
            bit_q      <= '0;
            ch_q       <= '0;
            settle_q   <= '0;
            ones_q     <= '0;
            samp_q     <= '0;
            code_q     <= '0;
            busy_q     <= 1'b0;
            stb_q      <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
`ifdef SKEW_SEARCH_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            run_prev_q <= run_i;
            work_q     <= work_d;
            bit_q      <= bit_d;
            ch_q       <= ch_d;
            settle_q   <= settle_d;
            ones_q     <= ones_d;
            samp_q     <= samp_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            stb_q      <= stb_d;
            done_q     <= done_d;
            result_q   <= result_d;
`ifdef SKEW_SEARCH_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign delay_code_o = code_q;
    assign ch_sel_o     = ch_q;
    assign stb_req_o    = stb_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
`ifdef SKEW_SEARCH_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_skew_search_ctl.sv
// Scoreboard bench for skew_search_ctl: threshold comparator model per channel, expected
// result vectors queued at sweep start and compared when done_o rises.
module tb_skew_search_ctl;
    localparam int CODE_W  = 10;
    localparam int N_CH    = 4;
    localparam int SAMPLES = 5;
    localparam int SETTLE  = 4;
    localparam int TMO     = 15;
    localparam int RW      = CODE_W * N_CH;

    logic              clk_i = 1'b0;
    logic              rst_i, run_i, cmp_out_i, stb_valid_i;
    logic              stb_req_o, busy_o, done_o, err_o;
    logic [CODE_W-1:0] delay_code_o;
    logic [1:0]        ch_sel_o;
    logic [RW-1:0]     result_o;

    logic [CODE_W-1:0] thr [N_CH];
    bit                noisy_en = 1'b0;
    int                noisy_k  = 0;
    int                noise_cnt = 0;
    int                checks = 0, failures = 0;
    logic [RW-1:0]     sb_q [$];

    skew_search_ctl #(
        .CODE_W(CODE_W), .N_CH(N_CH), .SAMPLES(SAMPLES), .SETTLE(SETTLE), .TMO(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .cmp_out_i(cmp_out_i),
        .delay_code_o(delay_code_o), .ch_sel_o(ch_sel_o), .stb_req_o(stb_req_o),
        .stb_valid_i(stb_valid_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    // Comparator: 1 while code <= channel threshold; optional forced vote on ch0 trial 0x200.
    always_comb begin
        if (noisy_en && ch_sel_o == 2'd0 && delay_code_o == 10'h200)
            cmp_out_i = (noise_cnt < noisy_k);
        else
            cmp_out_i = (delay_code_o <= thr[ch_sel_o]);
    end

    always @(posedge clk_i) begin
        if (!run_i)
            noise_cnt <= 0;
        else if (stb_req_o && stb_valid_i && ch_sel_o == 2'd0 && delay_code_o == 10'h200)
            noise_cnt <= noise_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_thr(input logic [CODE_W-1:0] t0, t1, t2, t3);
        thr[0] = t0; thr[1] = t1; thr[2] = t2; thr[3] = t3;
    endtask

    task automatic run_sweep(input string tag, input logic [RW-1:0] exp);
        int n;
        bit seen;
        logic [RW-1:0] want;
        sb_q.push_back(exp);
        run_i = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk_i);
            n++;
            if (done_o) seen = 1'b1;
        end
        want = sb_q.pop_front();
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_latency_in_window"}, 64'(n >= 440 && n <= 457), 64'd1);
            chk({tag, "_result"}, 64'(result_o), 64'(want));
            chk({tag, "_code_in_done"}, 64'(delay_code_o), 64'(want[RW-1 -: CODE_W]));
            chk({tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
        end
        run_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk({tag, "_done_held_idle"}, 64'(done_o), 64'(seen));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b1;
        run_i = 1'b0;
        stb_valid_i = 1'b1;
        set_thr(10'h155, 10'h155, 10'h155, 10'h155);
        repeat (2) @(negedge clk_i);
        chk("rst_code", 64'(delay_code_o), 64'd0);
        chk("rst_ch", 64'(ch_sel_o), 64'd0);
        chk("rst_stb", 64'(stb_req_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_sweep("uniform155", {4{10'h155}});

        set_thr(10'h000, 10'h3FF, 10'h200, 10'h1FF);
        run_sweep("edges", {10'h1FF, 10'h200, 10'h3FF, 10'h000});

        set_thr(10'h2A0, 10'h2A0, 10'h2A0, 10'h2A0);
        noisy_en = 1'b1;
        noisy_k  = 3;
        run_sweep("vote3of5", {4{10'h2A0}});
        noisy_k  = 2;
        run_sweep("vote2of5", {10'h2A0, 10'h2A0, 10'h2A0, 10'h1FF});
        noisy_en = 1'b0;

        // Abort in REQ of channel 2.
        set_thr(10'h155, 10'h155, 10'h155, 10'h155);
        run_i = 1'b1;
        n = 0;
        while (!(ch_sel_o == 2'd2 && stb_req_o) && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("abort_reached_ch2_req", 64'(ch_sel_o == 2'd2 && stb_req_o), 64'd1);
        run_i = 1'b0;
        @(negedge clk_i);
        chk("abort_stb", 64'(stb_req_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_result", 64'(result_o), 64'({10'h2A0, 10'h2A0, 10'h155, 10'h155}));
        @(negedge clk_i);
        thr[0] = 10'h0AA;
        run_i = 1'b1;
        @(negedge clk_i);
        chk("restart_ch0", 64'(ch_sel_o), 64'd0);
        chk("restart_busy", 64'(busy_o), 64'd1);
        run_i = 1'b0;
        repeat (2) @(negedge clk_i);
        run_sweep("restart", {10'h155, 10'h155, 10'h155, 10'h0AA});

        // Strobe never answered.
        stb_valid_i = 1'b0;
        run_i = 1'b1;
        n = 0;
        while (!stb_req_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("stall_req_seen", 64'(stb_req_o), 64'd1);
`ifdef SKEW_SEARCH_TIMEOUT_EN
        n = 0;
        while (!err_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("tmo_err_latency", 64'(n), 64'd16);
        chk("tmo_stb_low", 64'(stb_req_o), 64'd0);
        chk("tmo_busy_low", 64'(busy_o), 64'd0);
        run_i = 1'b0;
        @(negedge clk_i);
        chk("tmo_err_cleared", 64'(err_o), 64'd0);
`else
        repeat (40) @(negedge clk_i);
        chk("stall_stb_held", 64'(stb_req_o), 64'd1);
        chk("stall_no_err", 64'(err_o), 64'd0);
        chk("stall_busy", 64'(busy_o), 64'd1);
        run_i = 1'b0;
        @(negedge clk_i);
        chk("stall_abort_stb", 64'(stb_req_o), 64'd0);
`endif
        stb_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Reset pulse mid-sweep.
        run_i = 1'b1;
        repeat (200) @(negedge clk_i);
        chk("midrst_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_code", 64'(delay_code_o), 64'd0);
        chk("midrst_ch", 64'(ch_sel_o), 64'd0);
        chk("midrst_stb", 64'(stb_req_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_err", 64'(err_o), 64'd0);
        chk("midrst_result", 64'(result_o), 64'd0);
        rst_i = 1'b0;
        run_i = 1'b0;
        repeat (2) @(negedge clk_i);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
